// File: rtl/exmem_pkg.sv
// Shared types and constants for the external-memory Wishbone slave.
package exmem_pkg;
  localparam logic [7:0] EXMEM_BASE  = 8'h38;
  localparam int         DELAYS_DEF  = 10;
  localparam int         BRAM_RD_LAT = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK,
    S_PREFETCH
  } state_e;
endpackage

// File: rtl/exmem_bram.sv
// Single-port word-wide BRAM with byte write enables and a 1-cycle registered read.
module exmem_bram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       di_i,
  output logic [31:0]       do_o
);
  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= di_i[8*b +: 8];
      end
      do_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/exmem_ctrl.sv
// Wishbone slave emulating slow external memory over BRAM, with a one-word
// sequential read-prefetch buffer that turns the next-word read into a 1-cycle hit.
module exmem_ctrl
  import exmem_pkg::*;
#(
  parameter int DELAYS = DELAYS_DEF,
  parameter int ADDR_W = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);
  localparam int                CNT_W    = $clog2(DELAYS + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DELAYS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_RD   = CNT_W'(BRAM_RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   pf_addr_q, pf_addr_d;
  logic [31:0]         pf_data_q, pf_data_d;
  logic [31:0]         dat_q, dat_d;
  logic                we_q, we_d;
  logic                pend_q, pend_d;
  logic                pf_valid_q, pf_valid_d;
  logic                ack_q, ack_d;

  logic                req;
  logic                pf_hit_req;
  logic [ADDR_W-1:0]   req_addr;
  logic                rd_en, wr_en;
  logic                bram_en;
  logic [3:0]          bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic [31:0]         bram_do;
  logic                unused_adr;

  assign req        = wbs_cyc_i & wbs_stb_i;
  assign req_addr   = wbs_adr_i[ADDR_W+1:2];
  assign unused_adr = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};
  assign pf_hit_req = req && !pend_q && !wbs_we_i && (req_addr == pf_addr_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    pend_d     = pend_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
    ack_d      = 1'b0;
    dat_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = req_addr;
          we_d   = wbs_we_i;
          if (!wbs_we_i && pf_valid_q && (req_addr == pf_addr_q)) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            dat_d   = pf_data_q;
          end else begin
            state_d = S_ACCESS;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (!we_q) dat_d = bram_do;
          else if (addr_q == pf_addr_q) pf_valid_d = 1'b0;
        end
      end
      S_ACK: begin
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_PREFETCH;
          pf_addr_d  = addr_q + ADDR_ONE;
          pf_valid_d = 1'b0;
          cnt_d      = CNT_LOAD;
          pend_d     = 1'b0;
        end
      end
      S_PREFETCH: begin
        cnt_d = cnt_q - CNT_ONE;
        if (req && !pend_q && !pf_hit_req) begin
          // Anything but a read of the word being fetched restarts with full latency.
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          addr_d  = req_addr;
          we_d    = wbs_we_i;
        end else if (cnt_q == CNT_ONE) begin
          pf_data_d  = bram_do;
          pf_valid_d = 1'b1;
          if (pend_q || pf_hit_req) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            dat_d   = bram_do;
            pend_d  = 1'b0;
            addr_d  = pf_addr_q;
            we_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else if (pf_hit_req) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read enable is derived from next state so the data lands exactly on the capture edge,
  // which also covers the shortest latency where the enable falls in the request cycle.
  assign rd_en     = ((state_d == S_PREFETCH) || (state_d == S_ACCESS && !we_d)) && (cnt_d == CNT_RD);
  assign wr_en     = (state_q == S_ACCESS) && we_q && (cnt_q == CNT_ONE);
  assign bram_en   = !wb_rst_i && (rd_en || wr_en);
  assign bram_we   = (!wb_rst_i && wr_en) ? wbs_sel_i : 4'b0000;
  assign bram_addr = wr_en ? addr_q : ((state_d == S_PREFETCH) ? pf_addr_d : addr_d);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      pend_q     <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      pend_q     <= pend_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  exmem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk_i  (wb_clk_i),
    .en_i   (bram_en),
    .we_i   (bram_we),
    .addr_i (bram_addr),
    .di_i   (wbs_dat_i),
    .do_o   (bram_do)
  );
endmodule

// File: tb/tb_exmem_ctrl.sv
// Directed bench for exmem_ctrl with DELAYS=10: latency, byte writes, prefetch hits, aborts, wrap, reset.
module tb_exmem_ctrl;
  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, wdat, rdat;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          zero_bad = 0;
  int          lat, acks;
  logic [31:0] rd;

  always #5 clk = ~clk;

  exmem_ctrl #(.DELAYS(10), .ADDR_W(10)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Latency = number of edges from the request-sample edge to the ack cycle; 0 = no ack seen.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output int l, output logic [31:0] r);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    l = 0; r = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (ack) begin
        l = k;
        r = rdat;
        break;
      end else if (rdat != 32'h0) begin
        zero_bad++;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = 32'h3800_0000; wdat = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 32'h0);
      chk("rst_dat", rdat, 32'h0);
      chk("rst_bram_we", {28'b0, dut.bram_we}, 32'h0);
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;

    xfer(1'b1, 32'h3800_0000, 32'h1234_5678, 4'hF, lat, rd);
    chk("wr_lat", lat, 10);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("rd_miss_lat", lat, 10);
    chk("rd_miss_dat", rd, 32'h1234_5678);
    @(negedge clk);
    chk("ack_one_cycle", {31'b0, ack}, 32'h0);

    xfer(1'b1, 32'h3800_0000, 32'h1122_3344, 4'hF, lat, rd);
    chk("wr_full_lat", lat, 10);
    xfer(1'b1, 32'h3800_0000, 32'hAABB_CCDD, 4'b0010, lat, rd);
    chk("wr_byte_lat", lat, 10);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("byte_rd_lat", lat, 10);
    chk("byte_rd_dat", rd, 32'h1122_CC44);

    xfer(1'b1, 32'h3800_0004, 32'hCAFE_0001, 4'hF, lat, rd);
    chk("wr_w1_lat", lat, 10);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("rd_w0_lat", lat, 10);
    repeat (12) @(negedge clk);
    xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, lat, rd);
    chk("pf_hit_lat", lat, 1);
    chk("pf_hit_dat", rd, 32'hCAFE_0001);
    xfer(1'b0, 32'h3800_000C, 32'h0, 4'hF, lat, rd);
    chk("pf_skip_lat", lat, 10);

    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("rd_w0b_lat", lat, 10);
    repeat (2) @(negedge clk);
    xfer(1'b0, 32'h3800_0004, 32'h0, 4'hF, lat, rd);
    chk("pf_pend_lat", lat, 7);
    chk("pf_pend_dat", rd, 32'hCAFE_0001);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("rd_w0c_lat", lat, 10);
    repeat (2) @(negedge clk);
    xfer(1'b0, 32'h3800_0040, 32'h0, 4'hF, lat, rd);
    chk("pf_abort_lat", lat, 10);
    chk("pf_abort_valid", {31'b0, dut.pf_valid_q}, 32'h0);

    xfer(1'b1, 32'h3800_0FFC, 32'h0BAD_F00D, 4'hF, lat, rd);
    chk("wr_top_lat", lat, 10);
    xfer(1'b0, 32'h3800_0FFC, 32'h0, 4'hF, lat, rd);
    chk("rd_top_lat", lat, 10);
    chk("rd_top_dat", rd, 32'h0BAD_F00D);
    repeat (12) @(negedge clk);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("wrap_hit_lat", lat, 1);
    chk("wrap_hit_dat", rd, 32'h1122_CC44);
    xfer(1'b0, 32'h3800_0FFC, 32'h0, 4'hF, lat, rd);
    chk("rd_top2_lat", lat, 10);
    repeat (12) @(negedge clk);
    xfer(1'b1, 32'h3800_0000, 32'h5555_AAAA, 4'hF, lat, rd);
    chk("wr_inval_lat", lat, 10);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("inval_rd_lat", lat, 10);
    chk("inval_rd_dat", rd, 32'h5555_AAAA);

    acks = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3800_0040;
    repeat (4) begin
      @(negedge clk);
      if (ack) acks++;
    end
    rst = 1'b1;
    @(negedge clk);
    if (ack) acks++;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack) acks++;
    end
    chk("rst_abort_acks", acks, 0);
    xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, lat, rd);
    chk("post_rst_lat", lat, 10);
    chk("post_rst_dat", rd, 32'h5555_AAAA);

    chk("dat_zero_no_ack", zero_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
